dm_access_unit: RTL and testbench
=================================

Name: dm_access_unit

Overview:
- Memory-stage consumer of the execute-to-memory pipeline register outputs: takes the registered ALU result (address), store data and memory controls, and performs the data-memory access over a valid/ready bus.
- Generates byte enables and store-data lane replication, and sign- or zero-extends load data.
- Stalls the pipeline, by deasserting the pipeline-register enable upstream, while a transaction is outstanding.
- Flags misaligned or illegal accesses without touching the bus.

Parameters:
- TIMEOUT, 16, max cycles in REQ waiting for bus_ready before aborting with a fault (must be >=1)
- ADDR_W, 32, address width

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0)
- m_alu_y  input  32  access address from pipeline register
- m_write_data  input  32  store source register value
- m_mem_d_we  input  1  store request
- m_mem_d_re  input  1  load request
- m_funct3  input  3  access size/sign (RV32I encoding)
- stall  output  1  1 = hold all pipeline registers (enable low)
- m_read_data  output  32  extended load result, valid when done=1
- done  output  1  one-cycle pulse: access complete, pipeline may advance
- fault  output  1  one-cycle pulse: misaligned, illegal, or timed-out access
- bus_valid  output  1  request valid
- bus_we  output  1  write request
- bus_addr  output  ADDR_W  word-aligned address (low 2 bits zero)
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-replicated store data
- bus_ready  input  1  responder accepts/completes the request this cycle
- bus_rdata  input  32  read word, valid with bus_ready on a read

Behaviour:
- Reset (reset==0 at edge): state=IDLE; stall, done, fault, bus_valid, bus_we=0; bus_addr, bus_be, bus_wdata, m_read_data=0; timeout counter=0. Reset in mid-transaction drops bus_valid on that edge; no completion is reported.
- Request: req = m_mem_d_re | m_mem_d_we.
- Illegal access is any of:
  - both m_mem_d_re and m_mem_d_we high;
  - funct3 011/110/111;
  - a store with funct3 1xx;
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]!=0.
- States:
  - IDLE:
    - If req and illegal: fault=1 for the next cycle, no bus activity, stall=0, next IDLE.
    - If req and legal: register bus_addr, bus_be, bus_wdata, bus_we; next REQ.
    - stall = req & legal, combinational in IDLE.
  - REQ:
    - bus_valid=1, stall=1; counter increments each cycle.
    - On bus_ready: capture the extended bus_rdata into m_read_data (reads only; unchanged on writes); next DONE.
    - If the counter reaches TIMEOUT without bus_ready: drop bus_valid, fault=1 next cycle, next DONE.
    - bus_* outputs are stable throughout REQ.
  - DONE: done=1, stall=0, bus_valid=0, counter cleared; next IDLE. The pipeline advances on this edge, so the same instruction is never reissued.
- Latency: a legal access with bus_ready in its first REQ cycle stalls 2 cycles; done is asserted in the 3rd cycle after the request appears.
- Byte lanes, with o = addr[1:0]:
  - SB: be = 1<<o; wdata = {4{wd[7:0]}}.
  - SH: be = 0011 or 1100; wdata = {2{wd[15:0]}}.
  - SW: be = 1111.
  - Loads: be is set per size as for stores (informational to the responder).
- Load extend: select the byte/half by o. LB/LH sign-extend to 32; LBU/LHU zero-extend; LW passes the word through.
- m_read_data holds its value until the next completed read.

Decomposition:
- Package zeptron_dm_pkg:
  - dm_state_t enum {IDLE, REQ, DONE};
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - function is_illegal(funct3, addr_lo, re, we).
- Sub-module dm_align (combinational): computes bus_be and bus_wdata for stores and the extended read data for loads.
- dm_access_unit holds the FSM, the timeout counter and the output registers.

Test Plan:
1. SW addr=0x100, wd=0xDEADBEEF, bus_ready high in the first REQ cycle -> bus_valid=1, bus_we=1, be=1111, wdata=0xDEADBEEF; stall high 2 cycles; done pulse; fault=0.
2. LB addr=0x203, bus_rdata=0x80112233, ready after 3 cycles -> bus_addr=0x200, be=1000, m_read_data=0xFFFFFF80; stall high 4 cycles. Repeat as LBU -> 0x00000080.
3. SH addr=0x42, wd=0x0000ABCD -> be=1100, wdata=0xABCDABCD; then LH addr=0x41 -> fault pulse, bus_valid never asserted, stall=0.
4. LW addr=0x10 with bus_ready held low, TIMEOUT=16 -> bus_valid high for 16 cycles then drops; fault and done pulse together; m_read_data unchanged.
5. reset=0 asserted during REQ with bus_valid=1 -> next edge bus_valid=0, state IDLE, no done; after release, a new SW completes normally.
6. m_mem_d_re=m_mem_d_we=1, or funct3=011 -> fault pulse, no bus access; back-to-back legal LW then SW -> two separate done pulses, no reissue.

Source files
------------

// File: rtl/zeptron_dm_pkg.sv
// Shared types and helpers for the data-memory access unit: FSM states,
// RV32I load/store size encodings and the illegal-access check.
package zeptron_dm_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE} dm_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Only meaningful when a request is present; stores have no unsigned forms.
  function automatic logic is_illegal(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                      input logic re, input logic we);
    logic bad;
    bad = re & we;
    case (funct3)
      F3_B, F3_BU: bad = bad;
      F3_H, F3_HU: bad = bad | addr_lo[0];
      F3_W:        bad = bad | (addr_lo != 2'b00);
      default:     bad = 1'b1;
    endcase
    if (we && funct3[2]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dm_align.sv
// Byte-lane steering: byte enables and replicated store data on the way out,
// lane selection and sign/zero extension of load data on the way back.
module dm_align
  import zeptron_dm_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  always_comb begin
    w_byte  = i_rdata[8*i_off +: 8];
    w_half  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_funct3[2] ? {24'd0, w_byte} : 32'(w_byte);
      end
      2'b01: begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = i_funct3[2] ? {16'd0, w_half} : 32'(w_half);
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Memory-stage access unit: issues one valid/ready bus transaction per load or
// store, stalls the pipeline while it is outstanding, and faults bad accesses.
module dm_access_unit
  import zeptron_dm_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       m_alu_y,
  input  logic [31:0]       m_write_data,
  input  logic              m_mem_d_we,
  input  logic              m_mem_d_re,
  input  logic [2:0]        m_funct3,
  output logic              stall,
  output logic [31:0]       m_read_data,
  output logic              done,
  output logic              fault,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  dm_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic              r_valid, r_we, r_done, r_fault;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata, r_rdata;

  logic        w_req, w_illegal, w_idle;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_rext;

  assign w_req     = m_mem_d_re | m_mem_d_we;
  assign w_illegal = is_illegal(m_funct3, m_alu_y[1:0], m_mem_d_re, m_mem_d_we);
  assign w_idle    = (r_state == IDLE);

  // Aligner sees the live instruction in IDLE and the captured one while the
  // response is awaited, since bus_addr has its low bits cleared.
  assign w_f3  = w_idle ? m_funct3 : r_f3;
  assign w_off = w_idle ? m_alu_y[1:0] : r_off;

  dm_align u_align (
    .i_funct3 (w_f3),
    .i_off    (w_off),
    .i_wdata  (m_write_data),
    .i_rdata  (bus_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rext)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_f3    <= '0;
      r_off   <= '0;
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req && w_illegal) begin
            r_fault <= 1'b1;
          end else if (w_req) begin
            r_addr  <= {m_alu_y[ADDR_W-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_we    <= m_mem_d_we;
            r_f3    <= m_funct3;
            r_off   <= m_alu_y[1:0];
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (bus_ready) begin
            if (!r_we) r_rdata <= w_rext;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_fault <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign stall       = (w_idle & w_req & ~w_illegal) | (r_state == REQ);
  assign m_read_data = r_rdata;
  assign done        = r_done;
  assign fault       = r_fault;
  assign bus_valid   = r_valid;
  assign bus_we      = r_we;
  assign bus_addr    = r_addr;
  assign bus_be      = r_be;
  assign bus_wdata   = r_wdata;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed and randomized bench for dm_access_unit against an arithmetic
// model of sizes, lanes, alignment and extension.
module tb_dm_access_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_alu_y, m_write_data, m_read_data, bus_wdata, bus_rdata;
  logic        m_mem_d_we, m_mem_d_re, stall, done, fault;
  logic        bus_valid, bus_we, bus_ready;
  logic [2:0]  m_funct3;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_rd = 32'd0;

  always #5 clk = ~clk;

  dm_access_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .m_alu_y(m_alu_y), .m_write_data(m_write_data),
    .m_mem_d_we(m_mem_d_we), .m_mem_d_re(m_mem_d_re), .m_funct3(m_funct3),
    .stall(stall), .m_read_data(m_read_data), .done(done), .fault(fault),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sz_of(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic bit m_illegal(input bit re, input bit we, input logic [2:0] f3,
                                   input logic [31:0] a);
    if (re && we) return 1'b1;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    return (a % sz_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    longint lane, v;
    int sz;
    sz = sz_of(f3);
    lane = longint'(wd) % (64'd1 << (8 * sz));
    v = 0;
    for (int i = 0; i < 4 / sz; i++) v = v | (lane << (8 * sz * i));
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] rd);
    longint v;
    int sz;
    sz = sz_of(f3);
    if (sz == 4) return rd;
    v = (longint'(rd) >> (8 * (a % 4))) % (64'd1 << (8 * sz));
    if (f3 < 3'd4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  task automatic clear_inputs();
    m_mem_d_we = 1'b0; m_mem_d_re = 1'b0; m_funct3 = 3'd0;
    m_alu_y = 32'd0; m_write_data = 32'd0; bus_ready = 1'b0; bus_rdata = 32'd0;
  endtask

  // delay = REQ-cycle index in which bus_ready is raised; >= TO means never.
  task automatic access(input bit we, input bit re, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int delay, input logic [31:0] rd);
    bit legal, tmo;
    int sz;
    @(negedge clk);
    m_mem_d_we = we; m_mem_d_re = re; m_funct3 = f3; m_alu_y = a; m_write_data = wd;
    bus_ready = 1'b0;
    #1;
    legal = (re || we) && !m_illegal(re, we, f3, a);
    sz = sz_of(f3);
    chk("idle_done", done, 0);
    chk("idle_valid", bus_valid, 0);
    chk("idle_stall", stall, legal);
    if (!legal) begin
      @(negedge clk);
      chk("fault", fault, (re || we));
      chk("fault_valid", bus_valid, 0);
      chk("fault_done", done, 0);
      chk("fault_rd", m_read_data, exp_rd);
      clear_inputs();
      #1 chk("fault_stall", stall, 0);
      return;
    end
    tmo = (delay >= TO);
    for (int c = 0; c < TO; c++) begin
      @(negedge clk);
      chk("req_valid", bus_valid, 1);
      chk("req_stall", stall, 1);
      chk("req_done", done, 0);
      chk("req_we", bus_we, we);
      chk("req_addr", bus_addr, a & 32'hFFFF_FFFC);
      chk("req_be", bus_be, ((1 << sz) - 1) << (a % 4));
      if (we) chk("req_wdata", bus_wdata, m_wdata(f3, wd));
      bus_ready = (c == delay);
      bus_rdata = (c == delay) ? rd : $urandom;
      if (c == delay) break;
    end
    @(negedge clk);
    bus_ready = 1'b0;
    if (re && !tmo) exp_rd = m_ext(f3, a, rd);
    chk("done", done, 1);
    chk("done_fault", fault, tmo);
    chk("done_valid", bus_valid, 0);
    chk("done_stall", stall, 0);
    chk("done_rd", m_read_data, exp_rd);
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_be", {28'd0, bus_be}, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_rd", m_read_data, 0);
    reset = 1'b1;

    access(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0);
    access(0, 1, 3'b000, 32'h203, 0, 2, 32'h80112233);
    chk("lb_value", m_read_data, 32'hFFFFFF80);
    access(0, 1, 3'b100, 32'h203, 0, 2, 32'h80112233);
    chk("lbu_value", m_read_data, 32'h00000080);
    access(1, 0, 3'b001, 32'h42, 32'h0000ABCD, 0, 0);
    access(0, 1, 3'b001, 32'h41, 0, 0, 0);
    access(0, 1, 3'b010, 32'h10, 0, 99, 32'h12345678);
    chk("tmo_rd_kept", m_read_data, 32'h00000080);

    // Reset while a request is on the bus.
    @(negedge clk);
    m_mem_d_re = 1'b1; m_funct3 = 3'b010; m_alu_y = 32'h10;
    @(negedge clk);
    chk("mid_valid", bus_valid, 1);
    reset = 1'b0;
    @(negedge clk);
    clear_inputs();
    #1;
    chk("mid_rst_valid", bus_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_rd", m_read_data, 0);
    exp_rd = 32'd0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_post_done", done, 0);
    access(1, 0, 3'b010, 32'h200, 32'hCAFEF00D, 1, 0);

    access(1, 1, 3'b010, 32'h20, 32'h1, 0, 0);
    access(0, 1, 3'b011, 32'h20, 0, 0, 0);
    access(0, 1, 3'b010, 32'h20, 0, 0, 32'hA5A5_0F0F);
    access(1, 0, 3'b010, 32'h24, 32'h0BAD_F00D, 0, 0);
    access(1, 0, 3'b100, 32'h30, 32'h55, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int k, d;
      bit re, we;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      re = (k == 0) || (k >= 2 && k < 6);
      we = (k == 0) || (k >= 6);
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      d = ($urandom_range(0, 9) == 0) ? TO + 4 : $urandom_range(0, 4);
      access(we, re, 3'($urandom_range(0, 7)), a, $urandom, d, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
